// File: rtl/dram_cache_rob.sv
// Reorder buffer for DRAM-cache read completions: hands out transaction tags
// in order, accepts hit/miss completions in any order, and returns AXI R beats in tag order.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 3
`endif

module dram_cache_rob #(
    parameter int DATA_WIDTH   = `AXI_DATA_WIDTH,
    parameter int ID_WIDTH     = `AXI_ID_WIDTH,
    parameter int TID_WIDTH    = `TID_WIDTH,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            alloc_valid_i,
    input  logic [ID_WIDTH-1:0]             alloc_id_i,
    output logic                            alloc_ready_o,
    output logic [TID_WIDTH-1:0]            alloc_tid_o,
    input  logic                            rob_wren_i,
    input  logic [TID_WIDTH+DATA_WIDTH-1:0] rob_data_i,
    output logic                            rob_afull_o,
    input  logic                            miss_wren_i,
    input  logic [TID_WIDTH+DATA_WIDTH-1:0] miss_data_i,
    output logic [ID_WIDTH-1:0]             rid_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic [1:0]                      rresp_o,
    output logic                            rlast_o,
    output logic                            rvalid_o,
    input  logic                            rready_i,
    output logic                            err_o
);

    localparam int DEPTH = 1 << TID_WIDTH;
    localparam logic [TID_WIDTH:0] DEPTH_C   = (TID_WIDTH+1)'(DEPTH);
    localparam logic [TID_WIDTH:0] AFULL_LVL = (TID_WIDTH+1)'(DEPTH - AFULL_MARGIN);

    logic [DEPTH-1:0]      alloc_q, done_q, alloc_nxt, done_nxt;
    logic [ID_WIDTH-1:0]   id_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [TID_WIDTH-1:0]  head, tail;
    logic [TID_WIDTH:0]    count, done_cnt, count_nxt, done_cnt_nxt;

    logic [TID_WIDTH-1:0]  hit_tid, miss_tid;
    logic [DATA_WIDTH-1:0] hit_dat, miss_dat;
    logic                  hit_open, miss_open, same_tid;
    logic                  hit_ok, miss_ok, proto_err, load, alloc_fire;

    assign hit_tid  = rob_data_i[TID_WIDTH+DATA_WIDTH-1 -: TID_WIDTH];
    assign hit_dat  = rob_data_i[DATA_WIDTH-1:0];
    assign miss_tid = miss_data_i[TID_WIDTH+DATA_WIDTH-1 -: TID_WIDTH];
    assign miss_dat = miss_data_i[DATA_WIDTH-1:0];

    // A slot accepts exactly one completion between allocation and release.
    assign hit_open  = alloc_q[hit_tid] & ~done_q[hit_tid];
    assign miss_open = alloc_q[miss_tid] & ~done_q[miss_tid];
    assign same_tid  = rob_wren_i & miss_wren_i & (hit_tid == miss_tid);
    assign hit_ok    = rob_wren_i & hit_open;
    assign miss_ok   = miss_wren_i & miss_open & ~same_tid;
    assign proto_err = (rob_wren_i & ~hit_open) | (miss_wren_i & ~miss_open) | same_tid;

    assign alloc_ready_o = (count < DEPTH_C);
    assign alloc_tid_o   = tail;
    assign alloc_fire    = alloc_valid_i & alloc_ready_o;
    assign load          = (~rvalid_o | rready_i) & alloc_q[head] & done_q[head];

    assign count_nxt    = count + (TID_WIDTH+1)'(alloc_fire) - (TID_WIDTH+1)'(load);
    assign done_cnt_nxt = done_cnt + (TID_WIDTH+1)'(hit_ok) + (TID_WIDTH+1)'(miss_ok)
                          - (TID_WIDTH+1)'(load);

    always_comb begin
        alloc_nxt = alloc_q;
        done_nxt  = done_q;
        if (load) begin
            alloc_nxt[head] = 1'b0;
            done_nxt[head]  = 1'b0;
        end
        if (alloc_fire) begin
            alloc_nxt[tail] = 1'b1;
            done_nxt[tail]  = 1'b0;
        end
        if (hit_ok)  done_nxt[hit_tid]  = 1'b1;
        if (miss_ok) done_nxt[miss_tid] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_q     <= '0;
            done_q      <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            done_cnt    <= '0;
            rvalid_o    <= 1'b0;
            rid_o       <= '0;
            rdata_o     <= '0;
            rresp_o     <= 2'b00;
            rlast_o     <= 1'b0;
            rob_afull_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            alloc_q     <= alloc_nxt;
            done_q      <= done_nxt;
            count       <= count_nxt;
            done_cnt    <= done_cnt_nxt;
            rob_afull_o <= (done_cnt_nxt >= AFULL_LVL);
            err_o       <= err_o | proto_err;
            if (alloc_fire) tail <= tail + 1'b1;
            // R output register: holds its beat until the host takes it
            if (load) begin
                head     <= head + 1'b1;
                rvalid_o <= 1'b1;
                rid_o    <= id_q[head];
                rdata_o  <= data_q[head];
                rresp_o  <= 2'b00;
                rlast_o  <= 1'b1;
            end else if (rready_i) begin
                rvalid_o <= 1'b0;
            end
        end
    end

    // Payload storage is qualified by alloc/done bits, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) id_q[tail]       <= alloc_id_i;
        if (hit_ok)     data_q[hit_tid]  <= hit_dat;
        if (miss_ok)    data_q[miss_tid] <= miss_dat;
    end

endmodule

// File: tb/tb_dram_cache_rob.sv
// Scoreboard bench for dram_cache_rob: expected R beats are queued at allocation
// time and checked in order by a monitor as the host accepts them.
module tb_dram_cache_rob;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int TW = 3;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } beat_t;

    logic clk, rst_n;
    logic alloc_valid_i, alloc_ready_o;
    logic [IW-1:0] alloc_id_i;
    logic [TW-1:0] alloc_tid_o;
    logic rob_wren_i, miss_wren_i, rob_afull_o;
    logic [TW+DW-1:0] rob_data_i, miss_data_i;
    logic [IW-1:0] rid_o;
    logic [DW-1:0] rdata_o;
    logic [1:0] rresp_o;
    logic rlast_o, rvalid_o, rready_i, err_o;

    beat_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    dram_cache_rob #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .TID_WIDTH(TW), .AFULL_MARGIN(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid_i(alloc_valid_i), .alloc_id_i(alloc_id_i),
        .alloc_ready_o(alloc_ready_o), .alloc_tid_o(alloc_tid_o),
        .rob_wren_i(rob_wren_i), .rob_data_i(rob_data_i), .rob_afull_o(rob_afull_o),
        .miss_wren_i(miss_wren_i), .miss_data_i(miss_data_i),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard pop side: every accepted beat must match the oldest expected one
    always @(negedge clk) begin
        beat_t e;
        if (rst_n === 1'b1 && rvalid_o === 1'b1 && rready_i === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_beat: got rid=%0d rdata=%0h, required no beat", rid_o, rdata_o);
            end else begin
                e = sb.pop_front();
                if (rid_o !== e.id || rdata_o !== e.data || rresp_o !== 2'b00 || rlast_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL r_beat: got rid=%0d rdata=%0h rresp=%0d rlast=%0b, required rid=%0d rdata=%0h rresp=0 rlast=1",
                             rid_o, rdata_o, rresp_o, rlast_o, e.id, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        alloc_valid_i = 1'b0; alloc_id_i = '0;
        rob_wren_i = 1'b0; rob_data_i = '0;
        miss_wren_i = 1'b0; miss_data_i = '0;
        rready_i = 1'b0;
        sb.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic alloc(input logic [IW-1:0] id, input logic [DW-1:0] data);
        int n = 0;
        alloc_valid_i = 1'b1;
        alloc_id_i = id;
        while (alloc_ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL alloc_timeout: got alloc_ready_o=%0b, required 1 within 50 cycles", alloc_ready_o);
        end
        sb.push_back('{id: id, data: data});
        tick();
        alloc_valid_i = 1'b0;
    endtask

    task automatic wr(input bit he, input logic [TW-1:0] ht, input logic [DW-1:0] hd,
                      input bit me, input logic [TW-1:0] mt, input logic [DW-1:0] md);
        rob_wren_i = he; rob_data_i = {ht, hd};
        miss_wren_i = me; miss_data_i = {mt, md};
        tick();
        rob_wren_i = 1'b0;
        miss_wren_i = 1'b0;
    endtask

    task automatic drain(output bit ok);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        ok = (sb.size() == 0);
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alloc_valid_i = 1'b0; alloc_id_i = '0;
        rob_wren_i = 1'b0; rob_data_i = '0;
        miss_wren_i = 1'b0; miss_data_i = '0;
        rready_i = 1'b0;
        tick();
        vectors++;
        if (alloc_ready_o !== 1'b1) begin miscompares++; $display("FAIL rst_alloc_ready: got %0b, required 1", alloc_ready_o); end
        vectors++;
        if (alloc_tid_o !== 3'd0) begin miscompares++; $display("FAIL rst_alloc_tid: got %0d, required 0", alloc_tid_o); end
        vectors++;
        if (rvalid_o !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid: got %0b, required 0", rvalid_o); end
        vectors++;
        if ({rid_o, rdata_o, rresp_o, rlast_o} !== '0) begin
            miscompares++;
            $display("FAIL rst_r_fields: got rid=%0d rdata=%0h rresp=%0d rlast=%0b, required all 0", rid_o, rdata_o, rresp_o, rlast_o);
        end
        vectors++;
        if (rob_afull_o !== 1'b0) begin miscompares++; $display("FAIL rst_afull: got %0b, required 0", rob_afull_o); end
        vectors++;
        if (err_o !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %0b, required 0", err_o); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_in_order();
        do_reset();
        rready_i = 1'b1;
        alloc(4'd3, 64'hA);
        alloc(4'd5, 64'hB);
        vectors++;
        if (alloc_tid_o !== 3'd2) begin miscompares++; $display("FAIL order_tail: got %0d, required 2", alloc_tid_o); end
        wr(1'b1, 3'd1, 64'hB, 1'b0, 3'd0, 64'h0);
        tick();
        vectors++;
        if (rvalid_o !== 1'b0) begin miscompares++; $display("FAIL order_head_block: got rvalid=%0b, required 0", rvalid_o); end
        wr(1'b0, 3'd0, 64'h0, 1'b1, 3'd0, 64'hA);
        vectors++;
        if (rvalid_o !== 1'b0) begin miscompares++; $display("FAIL order_latency_early: got rvalid=%0b, required 0", rvalid_o); end
        tick();
        vectors++;
        if (rvalid_o !== 1'b1 || rid_o !== 4'd3 || rdata_o !== 64'hA) begin
            miscompares++;
            $display("FAIL order_beat0: got rvalid=%0b rid=%0d rdata=%0h, required 1/3/a", rvalid_o, rid_o, rdata_o);
        end
        tick();
        vectors++;
        if (rvalid_o !== 1'b1 || rid_o !== 4'd5 || rdata_o !== 64'hB) begin
            miscompares++;
            $display("FAIL order_beat1: got rvalid=%0b rid=%0d rdata=%0h, required 1/5/b", rvalid_o, rid_o, rdata_o);
        end
        tick();
        vectors++;
        if (rvalid_o !== 1'b0) begin miscompares++; $display("FAIL order_drop: got rvalid=%0b, required 0", rvalid_o); end
        vectors++;
        if (err_o !== 1'b0) begin miscompares++; $display("FAIL order_err: got %0b, required 0", err_o); end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(IW'(i), 64'(256 + i));
        vectors++;
        if (alloc_ready_o !== 1'b0) begin miscompares++; $display("FAIL wrap_full: got alloc_ready=%0b, required 0", alloc_ready_o); end
        rready_i = 1'b1;
        wr(1'b0, 3'd0, 64'h0, 1'b1, 3'd0, 64'd256);
        vectors++;
        if (alloc_ready_o !== 1'b0) begin miscompares++; $display("FAIL wrap_before_release: got alloc_ready=%0b, required 0", alloc_ready_o); end
        tick();
        vectors++;
        if (alloc_ready_o !== 1'b1 || alloc_tid_o !== 3'd0) begin
            miscompares++;
            $display("FAIL wrap_after_release: got alloc_ready=%0b tid=%0d, required 1/0", alloc_ready_o, alloc_tid_o);
        end
        alloc(4'd9, 64'h200);
        for (int t = 1; t < DEPTH; t++) wr(1'b1, TW'(t), 64'(256 + t), 1'b0, 3'd0, 64'h0);
        wr(1'b0, 3'd0, 64'h0, 1'b1, 3'd0, 64'h200);
        drain(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL wrap_drain: got %0d beats left, required 0", sb.size()); end
    endtask

    task automatic test_collide();
        bit ok;
        do_reset();
        rready_i = 1'b1;
        alloc(4'd1, 64'h10);
        alloc(4'd2, 64'h11);
        alloc(4'd4, 64'h1);
        wr(1'b1, 3'd2, 64'h1, 1'b1, 3'd2, 64'h2);
        vectors++;
        if (err_o !== 1'b1) begin miscompares++; $display("FAIL collide_err: got %0b, required 1", err_o); end
        wr(1'b1, 3'd0, 64'h10, 1'b1, 3'd1, 64'h11);
        drain(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL collide_drain: got %0d beats left, required 0", sb.size()); end
        do_reset();
        rready_i = 1'b1;
        alloc(4'd6, 64'h21);
        alloc(4'd7, 64'h22);
        wr(1'b1, 3'd1, 64'h22, 1'b1, 3'd0, 64'h21);
        drain(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL distinct_drain: got %0d beats left, required 0", sb.size()); end
        vectors++;
        if (err_o !== 1'b0) begin miscompares++; $display("FAIL distinct_err: got %0b, required 0", err_o); end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(IW'(i), 64'(768 + i));
        wr(1'b0, 3'd0, 64'h0, 1'b1, 3'd0, 64'd768);
        wr(1'b1, 3'd1, 64'd769, 1'b0, 3'd0, 64'h0);
        wr(1'b0, 3'd0, 64'h0, 1'b1, 3'd2, 64'd770);
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (rvalid_o !== 1'b1 || rid_o !== 4'd0 || rdata_o !== 64'd768) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got rvalid=%0b rid=%0d rdata=%0h, required 1/0/300", k, rvalid_o, rid_o, rdata_o);
            end
        end
        vectors++;
        if (rob_afull_o !== 1'b0) begin miscompares++; $display("FAIL bp_afull_low: got %0b, required 0", rob_afull_o); end
        for (int t = 3; t <= 5; t++) wr(1'b1, TW'(t), 64'(768 + t), 1'b0, 3'd0, 64'h0);
        vectors++;
        if (rob_afull_o !== 1'b0) begin miscompares++; $display("FAIL bp_afull_5: got %0b, required 0", rob_afull_o); end
        wr(1'b1, 3'd6, 64'd774, 1'b0, 3'd0, 64'h0);
        vectors++;
        if (rob_afull_o !== 1'b1) begin miscompares++; $display("FAIL bp_afull_6: got %0b, required 1", rob_afull_o); end
        wr(1'b0, 3'd0, 64'h0, 1'b1, 3'd7, 64'd775);
        rready_i = 1'b1;
        drain(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL bp_drain: got %0d beats left, required 0", sb.size()); end
        vectors++;
        if (rob_afull_o !== 1'b0) begin miscompares++; $display("FAIL bp_afull_clear: got %0b, required 0", rob_afull_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rready_i = 1'b1;
        for (int i = 0; i < 4; i++) alloc(IW'(8 + i), 64'(1024 + i));
        for (int t = 3; t >= 1; t--) wr(1'b1, TW'(t), 64'(1024 + t), 1'b0, 3'd0, 64'h0);
        wr(1'b0, 3'd0, 64'h0, 1'b1, 3'd0, 64'd1024);
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (rvalid_o !== 1'b1 || rid_o !== IW'(8 + k)) begin
                miscompares++;
                $display("FAIL b2b_beat%0d: got rvalid=%0b rid=%0d, required 1/%0d", k, rvalid_o, rid_o, 8 + k);
            end
        end
        tick();
        vectors++;
        if (rvalid_o !== 1'b0) begin miscompares++; $display("FAIL b2b_drop: got rvalid=%0b, required 0", rvalid_o); end
    endtask

    task automatic test_err_unalloc();
        bit ok;
        bit seen;
        do_reset();
        rready_i = 1'b1;
        wr(1'b1, 3'd7, 64'hDEAD, 1'b0, 3'd0, 64'h0);
        vectors++;
        if (err_o !== 1'b1) begin miscompares++; $display("FAIL unalloc_err: got %0b, required 1", err_o); end
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (rvalid_o !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin miscompares++; $display("FAIL unalloc_beat: got rvalid=1, required no beat"); end
        rready_i = 1'b0;
        alloc(4'd2, 64'h77);
        wr(1'b1, 3'd0, 64'h77, 1'b0, 3'd0, 64'h0);
        wr(1'b0, 3'd0, 64'h0, 1'b1, 3'd0, 64'h88);
        rready_i = 1'b1;
        drain(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL dup_drain: got %0d beats left, required 0", sb.size()); end
        vectors++;
        if (err_o !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %0b, required 1", err_o); end
        do_reset();
        vectors++;
        if (err_o !== 1'b0) begin miscompares++; $display("FAIL err_reset: got %0b, required 0", err_o); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        do_reset();
        for (int i = 0; i < 5; i++) alloc(IW'(1 + i), 64'(1536 + i));
        wr(1'b0, 3'd0, 64'h0, 1'b1, 3'd0, 64'd1536);
        wr(1'b1, 3'd1, 64'd1537, 1'b1, 3'd2, 64'd1538);
        vectors++;
        if (rvalid_o !== 1'b1) begin miscompares++; $display("FAIL mid_pre_rvalid: got %0b, required 1", rvalid_o); end
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rvalid_o !== 1'b0 || alloc_tid_o !== 3'd0 || alloc_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: got rvalid=%0b tid=%0d ready=%0b, required 0/0/1", rvalid_o, alloc_tid_o, alloc_ready_o);
        end
        sb.delete();
        tick();
        rst_n = 1'b1;
        rready_i = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rvalid_o !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin miscompares++; $display("FAIL mid_stale_beat: got rvalid=1, required no beat"); end
        alloc(4'd13, 64'h700);
        wr(1'b1, 3'd0, 64'h700, 1'b0, 3'd0, 64'h0);
        drain(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL mid_fresh_drain: got %0d beats left, required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_wrap();
        test_collide();
        test_backpressure();
        test_back_to_back();
        test_err_unalloc();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dram_cache_rob.md
DRAM_CACHE_ROB -- requirements
Module: dram_cache_rob

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `AXI_DATA_WIDTH, read data beat width.
REQ-002 SHALL have parameter ID_WIDTH, default `AXI_ID_WIDTH, AXI ID width.
REQ-003 SHALL have parameter TID_WIDTH, default `TID_WIDTH, transaction tag width; DEPTH = 2^TID_WIDTH slots.
REQ-004 SHALL have parameter AFULL_MARGIN, default 2, completed-slot margin for rob_afull_o.
REQ-005 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have alloc_valid_i  input  1  read request wants a TID.
REQ-008 SHALL have alloc_id_i  input  ID_WIDTH  AXI ARID to return on R.
REQ-009 SHALL have alloc_ready_o  output  1  slot available.
REQ-010 SHALL have alloc_tid_o  output  TID_WIDTH  TID granted on alloc fire.
REQ-011 SHALL have rob_wren_i / rob_data_i  input  1 / TID_WIDTH+DATA_WIDTH  read-hit completion from tag comparator, {tid, data}.
REQ-012 SHALL have rob_afull_o  output  1  almost-full to tag comparator.
REQ-013 SHALL have miss_wren_i / miss_data_i  input  1 / TID_WIDTH+DATA_WIDTH  read-miss completion from main-memory return path, {tid, data}.
REQ-014 SHALL have rid_o, rdata_o, rresp_o, rlast_o, rvalid_o  output  ID_WIDTH, DATA_WIDTH, 2, 1, 1  AXI R to host.
REQ-015 SHALL have rready_i  input  1  AXI R ready.
REQ-016 SHALL have err_o  output  1  sticky protocol-error flag.

Function
REQ-017 SHALL keep per slot: alloc bit, done bit, ID, data; head/tail pointers TID_WIDTH wide, wrap modulo DEPTH; occupancy count TID_WIDTH+1 wide.
REQ-018 SHALL drive alloc_ready_o = (count < DEPTH), alloc_tid_o = tail, combinationally from registered state.
REQ-019 On alloc fire (valid&ready) SHALL set slot[tail].alloc=1, done=0, store ID, tail+1.
REQ-020 On rob_wren_i or miss_wren_i SHALL store data into slot[tid], set done=1, visible next cycle.
REQ-021 Hit and miss writes to different TIDs in one cycle SHALL both complete.
REQ-022 Hit and miss writes to same TID in one cycle: hit data SHALL win, err_o set.
REQ-023 Write to slot with alloc=0 or done=1 SHALL be ignored and set err_o; err_o clears only on reset.
REQ-024 Output stage SHALL be one register; load when (!rvalid_o | rready_i) and slot[head].alloc & done.
REQ-025 On load SHALL drive rid_o=slot ID, rdata_o=slot data, rresp_o=2'b00, rlast_o=1, rvalid_o=1; clear slot alloc/done; head+1; count-1.
REQ-026 rvalid_o SHALL drop after rvalid_o&rready_i when no loadable head; rdata_o/rid_o SHALL stay stable while rvalid_o&!rready_i.
REQ-027 Latency: write accepted at edge E to head slot -> rvalid_o high after edge E+1; back-to-back done slots drain one per cycle with rready_i=1.
REQ-028 Responses SHALL leave strictly in allocation order regardless of completion order.
REQ-029 Alloc and release in same cycle SHALL leave count unchanged; at count==DEPTH alloc refused that cycle even if releasing.
REQ-030 rob_afull_o SHALL be registered, 1 when done-slot count (done, not yet loaded) >= DEPTH-AFULL_MARGIN.
REQ-031 Slot at head with alloc=1, done=0 SHALL block all younger completed slots.

Reset
REQ-032 While rst_n=0 SHALL clear all alloc/done bits, head=tail=count=0, rvalid_o=0, rid_o=0, rdata_o=0, rresp_o=0, rlast_o=0, rob_afull_o=0, err_o=0; alloc_ready_o=1, alloc_tid_o=0.
REQ-033 Reset mid-operation SHALL discard all pending slots and output beat immediately; no R beat issued for pre-reset TIDs.

Verification
REQ-034 Alloc IDs 3,5 (TIDs 0,1); hit write TID1=0xB, then miss write TID0=0xA -> R beats {rid=3,0xA} then {rid=5,0xB}, rlast=1, rresp=0.
REQ-035 Fill all DEPTH slots -> alloc_ready_o=0; complete TID0, rready_i=1 -> alloc_ready_o=1 cycle after release, next alloc_tid_o=0 (wrap).
REQ-036 Same-cycle hit and miss writes to TID2 with data 0x1/0x2 -> delivered data 0x1, err_o=1; distinct TIDs -> both delivered, err_o=0.
REQ-037 Hold rready_i=0 with 3 done slots -> rvalid_o=1, rdata_o stable; rob_afull_o=1 when done count reaches DEPTH-2.
REQ-038 Write to unallocated TID7 -> no R beat, err_o=1 until reset.
REQ-039 Assert rst_n=0 with rvalid_o=1 and 4 slots pending -> rvalid_o=0 immediately, alloc_tid_o=0, no stale beat after release.
